// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: special instruction words and
// the fetch-stage FSM encoding.
package mips_pkg;

   localparam int          WORD_W    = 32;
   localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
   localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      HALT = 2'd3
   } fetch_state_e;

   // Program bytes arrive little-endian; the last byte is the top of the word.
   function automatic logic [31:0] assemble_word(input logic [23:0] low_bytes,
                                                 input logic [7:0]  top_byte);
      return {top_byte, low_bytes};
   endfunction

endpackage

// File: rtl/instruction_memory.sv
// Word-addressed instruction store: one synchronous write port for the
// program loader, one combinational read port for fetch. Contents are never reset.
module instruction_memory #(
   parameter int MEM_DEPTH = 256,
   parameter int AW        = $clog2(MEM_DEPTH),
   parameter int WORD_W    = 32
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [AW-1:0]     i_waddr,
   input  logic [WORD_W-1:0] i_wdata,
   input  logic [AW-1:0]     i_raddr,
   output logic [WORD_W-1:0] o_rdata
);

   logic [WORD_W-1:0] mem_q [MEM_DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         mem_q[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/instruction_fetch_unit.sv
// MIPS instruction fetch stage: program counter, byte-wise program loader,
// HALT detection and the IF/ID pipeline register.
module instruction_fetch_unit
   import mips_pkg::*;
#(
   parameter  int NBITS     = 32,
   parameter  int MEM_DEPTH = 256,
   localparam int AW        = $clog2(MEM_DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic             i_stall,
   input  logic             i_flush,
   input  logic             i_redirect,
   input  logic [NBITS-1:0] i_redirect_addr,
   input  logic             i_ld_start,
   input  logic             i_ld_valid,
   input  logic [7:0]       i_ld_byte,
   input  logic             i_run,
   output logic [NBITS-1:0] o_pc,
   output logic [NBITS-1:0] o_instruction,
   output logic             o_valid,
   output logic             o_halted,
   output logic             o_ld_done,
   output logic [AW:0]      o_ld_words
);

   fetch_state_e state_q, state_d;

   logic [NBITS-1:0] pc_q, pc_d;
   logic [NBITS-1:0] if_pc_q, if_pc_d;
   logic [NBITS-1:0] if_instr_q, if_instr_d;
   logic             valid_q, valid_d;
   logic             ld_done_q, ld_done_d;
   logic [AW:0]      ld_words_q, ld_words_d;
   logic [1:0]       byte_cnt_q, byte_cnt_d;
   logic [23:0]      asm_q, asm_d;

   logic             mem_we;
   logic [AW-1:0]    mem_waddr;
   logic [31:0]      mem_wdata;
   logic [31:0]      fetch_word;
   logic [NBITS-1:0] pc_plus4;
   logic             advance;
   logic             last_load_word;

   assign pc_plus4       = pc_q + NBITS'(4);
   assign advance        = i_en & ~i_stall;
   assign mem_waddr      = ld_words_q[AW-1:0];
   assign mem_wdata      = assemble_word(asm_q, i_ld_byte);
   assign last_load_word = (mem_wdata == HALT_WORD) ||
                           (ld_words_q == (AW+1)'(MEM_DEPTH - 1));

   instruction_memory #(
      .MEM_DEPTH (MEM_DEPTH),
      .AW        (AW),
      .WORD_W    (32)
   ) u_imem (
      .i_clk   (i_clk),
      .i_we    (mem_we),
      .i_waddr (mem_waddr),
      .i_wdata (mem_wdata),
      .i_raddr (pc_q[AW+1:2]),
      .o_rdata (fetch_word)
   );

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      if_pc_d    = if_pc_q;
      if_instr_d = if_instr_q;
      valid_d    = valid_q;
      ld_done_d  = 1'b0;
      ld_words_d = ld_words_q;
      byte_cnt_d = byte_cnt_q;
      asm_d      = asm_q;
      mem_we     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (i_ld_start) begin
               state_d    = LOAD;
               byte_cnt_d = 2'd0;
               ld_words_d = '0;
               asm_d      = '0;
            end else if (i_run) begin
               state_d = RUN;
               pc_d    = '0;
            end
         end

         LOAD: begin
            if (i_ld_valid) begin
               if (byte_cnt_q == 2'd3) begin
                  mem_we     = 1'b1;
                  ld_words_d = ld_words_q + (AW+1)'(1);
                  byte_cnt_d = 2'd0;
                  if (last_load_word) begin
                     state_d   = IDLE;
                     ld_done_d = 1'b1;
                  end
               end else begin
                  case (byte_cnt_q)
                     2'd0:    asm_d[7:0]   = i_ld_byte;
                     2'd1:    asm_d[15:8]  = i_ld_byte;
                     default: asm_d[23:16] = i_ld_byte;
                  endcase
                  byte_cnt_d = byte_cnt_q + 2'd1;
               end
            end
         end

         RUN: begin
            if (i_en) begin
               if (advance && fetch_word == HALT_WORD) begin
                  // PC stays parked on the HALT word; the stage stops for good.
                  if_pc_d    = pc_plus4;
                  if_instr_d = NBITS'(NOP_WORD);
                  valid_d    = 1'b0;
                  state_d    = HALT;
               end else begin
                  if (advance) begin
                     if_pc_d    = pc_plus4;
                     if_instr_d = NBITS'(fetch_word);
                     valid_d    = 1'b1;
                     pc_d       = pc_plus4;
                  end
                  // Redirect and flush come from later stages and win over a stall.
                  if (i_redirect) begin
                     pc_d = i_redirect_addr;
                  end
                  if (i_flush) begin
                     if_pc_d    = pc_plus4;
                     if_instr_d = NBITS'(NOP_WORD);
                     valid_d    = 1'b0;
                  end
               end
            end
         end

         HALT: begin
            if (i_en && i_flush) begin
               if_instr_d = NBITS'(NOP_WORD);
               valid_d    = 1'b0;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= IDLE;
         pc_q       <= '0;
         if_pc_q    <= '0;
         if_instr_q <= '0;
         valid_q    <= 1'b0;
         ld_done_q  <= 1'b0;
         ld_words_q <= '0;
         byte_cnt_q <= 2'd0;
         asm_q      <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         if_pc_q    <= if_pc_d;
         if_instr_q <= if_instr_d;
         valid_q    <= valid_d;
         ld_done_q  <= ld_done_d;
         ld_words_q <= ld_words_d;
         byte_cnt_q <= byte_cnt_d;
         asm_q      <= asm_d;
      end
   end

   assign o_pc          = if_pc_q;
   assign o_instruction = if_instr_q;
   assign o_valid       = valid_q;
   assign o_halted      = (state_q == HALT);
   assign o_ld_done     = ld_done_q;
   assign o_ld_words    = ld_words_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: directed loads, runs, stalls,
// redirects, flushes and resets with hand-computed expected IF/ID contents.
module tb_instruction_fetch_unit;

   localparam logic [31:0] HW = 32'hFFFF_FFFF;

   logic        i_clk = 1'b0;
   logic        i_rst, i_en, i_stall, i_flush, i_redirect;
   logic [31:0] i_redirect_addr;
   logic        i_ld_start, i_ld_valid, i_run;
   logic [7:0]  i_ld_byte;
   logic [31:0] o_pc, o_instruction;
   logic        o_valid, o_halted, o_ld_done;
   logic [8:0]  o_ld_words;

   always #5 i_clk = ~i_clk;

   instruction_fetch_unit #(.NBITS(32), .MEM_DEPTH(256)) dut (
      .i_clk           (i_clk),
      .i_rst           (i_rst),
      .i_en            (i_en),
      .i_stall         (i_stall),
      .i_flush         (i_flush),
      .i_redirect      (i_redirect),
      .i_redirect_addr (i_redirect_addr),
      .i_ld_start      (i_ld_start),
      .i_ld_valid      (i_ld_valid),
      .i_ld_byte       (i_ld_byte),
      .i_run           (i_run),
      .o_pc            (o_pc),
      .o_instruction   (o_instruction),
      .o_valid         (o_valid),
      .o_halted        (o_halted),
      .o_ld_done       (o_ld_done),
      .o_ld_words      (o_ld_words)
   );

   typedef struct packed {
      int          cyc;
      logic [31:0] pc;
      logic [31:0] ins;
      logic        v;
      logic        h;
      logic        d;
      logic [8:0]  w;
   } exp_t;

   exp_t  sb[$];
   string nm_q[$];
   int    cyc   = 0;
   int    total = 0;
   int    bad   = 0;

   always @(posedge i_clk) cyc <= cyc + 1;

   // Expected outputs after the next rising edge.
   task automatic expect_next(input string nm, input logic [31:0] pc, input logic [31:0] ins,
                              input logic v, input logic h, input logic d, input int w);
      exp_t e;
      e.cyc = cyc + 1;
      e.pc  = pc;
      e.ins = ins;
      e.v   = v;
      e.h   = h;
      e.d   = d;
      e.w   = 9'(w);
      sb.push_back(e);
      nm_q.push_back(nm);
   endtask

   task automatic tick;
      @(posedge i_clk);
      #1;
   endtask

   task automatic load_word(input logic [31:0] w, input int words_before, input bit last);
      for (int b = 0; b < 4; b++) begin
         i_ld_valid = 1'b1;
         i_ld_byte  = w[8*b +: 8];
         if (b == 3) expect_next("ld_word_write", 0, 0, 0, 0, last, words_before + 1);
         else        expect_next("ld_byte", 0, 0, 0, 0, 0, words_before);
         tick();
      end
      i_ld_valid = 1'b0;
   endtask

   function automatic logic [31:0] cw(input int i);
      return 32'h1000_0000 + 32'(i);
   endfunction

   // Monitor: pops and compares each expectation in the cycle it is due.
   initial begin
      exp_t  me;
      string mn;
      forever begin
         @(negedge i_clk);
         while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            me = sb.pop_front();
            mn = nm_q.pop_front();
            total++;
            if (me.cyc != cyc) begin
               bad++;
               $display("FAIL %s: checked at cycle %0d, was due at cycle %0d", mn, cyc, me.cyc);
            end else if (o_pc !== me.pc || o_instruction !== me.ins || o_valid !== me.v ||
                         o_halted !== me.h || o_ld_done !== me.d || o_ld_words !== me.w) begin
               bad++;
               $display("FAIL %s @%0d: got pc=%h ins=%h vld=%b halt=%b done=%b words=%0d; want pc=%h ins=%h vld=%b halt=%b done=%b words=%0d",
                        mn, cyc, o_pc, o_instruction, o_valid, o_halted, o_ld_done, o_ld_words,
                        me.pc, me.ins, me.v, me.h, me.d, me.w);
            end
         end
      end
   end

   initial begin
      i_rst = 1'b1; i_en = 1'b0; i_stall = 1'b0; i_flush = 1'b0; i_redirect = 1'b0;
      i_redirect_addr = '0; i_ld_start = 1'b0; i_ld_valid = 1'b0; i_ld_byte = '0; i_run = 1'b0;

      // Reset defaults
      tick();
      expect_next("in_reset", 0, 0, 0, 0, 0, 0);
      tick();
      i_rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         expect_next("reset_idle", 0, 0, 0, 0, 0, 0);
         tick();
      end

      // Load A: two words, HALT terminates
      i_en = 1'b1;
      i_ld_start = 1'b1;
      expect_next("ldA_start", 0, 0, 0, 0, 0, 0);
      tick();
      i_ld_start = 1'b0;
      load_word(32'h2401_0013, 0, 0);
      load_word(HW, 1, 1);
      expect_next("ldA_done_pulse_end", 0, 0, 0, 0, 0, 2);
      tick();

      // Load B: ld_start beats run, run ignored while loading
      i_ld_start = 1'b1;
      i_run      = 1'b1;
      expect_next("ldB_start_wins", 0, 0, 0, 0, 0, 0);
      tick();
      i_ld_start = 1'b0;
      load_word(32'h2401_0013, 0, 0);
      load_word(32'h2402_0005, 1, 0);
      load_word(32'h0022_1820, 2, 0);
      i_run = 1'b0;
      load_word(HW, 3, 1);
      expect_next("ldB_idle", 0, 0, 0, 0, 0, 4);
      tick();

      // Sequential fetch to HALT
      i_run = 1'b1;
      expect_next("runB_enter", 0, 0, 0, 0, 0, 4);
      tick();
      i_run = 1'b0;
      expect_next("seq_w0", 32'd4,  32'h2401_0013, 1, 0, 0, 4); tick();
      expect_next("seq_w1", 32'd8,  32'h2402_0005, 1, 0, 0, 4); tick();
      expect_next("seq_w2", 32'd12, 32'h0022_1820, 1, 0, 0, 4); tick();
      expect_next("seq_halt", 32'd16, 0, 0, 1, 0, 4); tick();
      for (int k = 0; k < 10; k++) begin
         expect_next("halt_hold", 32'd16, 0, 0, 1, 0, 4);
         tick();
      end

      i_rst = 1'b1;
      expect_next("rst_from_halt", 0, 0, 0, 0, 0, 0);
      tick();
      i_rst = 1'b0;

      // Load C: words 0..9 plus HALT at word 10
      i_ld_start = 1'b1;
      expect_next("ldC_start", 0, 0, 0, 0, 0, 0);
      tick();
      i_ld_start = 1'b0;
      for (int i = 0; i < 10; i++) load_word(cw(i), i, 0);
      load_word(HW, 10, 1);
      expect_next("ldC_idle", 0, 0, 0, 0, 0, 11);
      tick();

      i_run = 1'b1;
      expect_next("runC_enter", 0, 0, 0, 0, 0, 11);
      tick();
      i_run = 1'b0;
      expect_next("runC_w0", 32'd4, cw(0), 1, 0, 0, 11); tick();
      expect_next("runC_w1", 32'd8, cw(1), 1, 0, 0, 11); tick();

      // Stall and enable freeze at PC=8
      i_stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         expect_next("stall_hold", 32'd8, cw(1), 1, 0, 0, 11);
         tick();
      end
      i_stall = 1'b0;
      i_en = 1'b0; i_flush = 1'b1; i_redirect = 1'b1; i_redirect_addr = 32'h40;
      for (int k = 0; k < 2; k++) begin
         expect_next("en_low_hold", 32'd8, cw(1), 1, 0, 0, 11);
         tick();
      end
      i_en = 1'b1; i_flush = 1'b0; i_redirect = 1'b0;
      expect_next("resume_w2", 32'd12, cw(2), 1, 0, 0, 11); tick();

      // Redirect during stall
      i_stall = 1'b1; i_redirect = 1'b1; i_redirect_addr = 32'h20;
      expect_next("redir_stall_hold", 32'd12, cw(2), 1, 0, 0, 11); tick();
      i_stall = 1'b0; i_redirect = 1'b0;
      expect_next("redir_target_w8", 32'h24, cw(8), 1, 0, 0, 11); tick();

      // Flush during stall
      i_stall = 1'b1; i_flush = 1'b1;
      expect_next("flush_stall", 32'h28, 0, 0, 0, 0, 11); tick();
      i_stall = 1'b0; i_flush = 1'b0;

      // Redirect on an advance; upper PC bits do not affect the word index
      i_redirect = 1'b1; i_redirect_addr = 32'h404;
      expect_next("adv_redir_w9", 32'h28, cw(9), 1, 0, 0, 11); tick();
      i_redirect = 1'b0;
      expect_next("wrap_w1", 32'h408, cw(1), 1, 0, 0, 11); tick();
      i_redirect = 1'b1; i_redirect_addr = 32'h28;
      expect_next("adv_redir_w2", 32'h40C, cw(2), 1, 0, 0, 11); tick();
      i_redirect = 1'b0;
      expect_next("runC_halt", 32'h2C, 0, 0, 1, 0, 11); tick();
      i_ld_start = 1'b1; i_ld_valid = 1'b1; i_ld_byte = 8'hAA;
      for (int k = 0; k < 3; k++) begin
         expect_next("halt_ignores_load", 32'h2C, 0, 0, 1, 0, 11);
         tick();
      end
      i_ld_start = 1'b0; i_ld_valid = 1'b0;

      i_rst = 1'b1;
      expect_next("rst_C", 0, 0, 0, 0, 0, 0);
      tick();
      i_rst = 1'b0;

      // Reset in the middle of word 1 of a load
      i_ld_start = 1'b1;
      expect_next("ldD_start", 0, 0, 0, 0, 0, 0);
      tick();
      i_ld_start = 1'b0;
      load_word(32'h3C01_ABCD, 0, 0);
      i_ld_valid = 1'b1; i_ld_byte = 8'h11;
      expect_next("ldD_partial0", 0, 0, 0, 0, 0, 1); tick();
      i_ld_byte = 8'h22;
      expect_next("ldD_partial1", 0, 0, 0, 0, 0, 1); tick();
      i_ld_valid = 1'b0;
      i_rst = 1'b1;
      expect_next("rst_mid_load", 0, 0, 0, 0, 0, 0); tick();
      i_rst = 1'b0;
      i_run = 1'b1;
      expect_next("runD_enter", 0, 0, 0, 0, 0, 0); tick();
      i_run = 1'b0;
      expect_next("runD_w0_kept", 32'd4,  32'h3C01_ABCD, 1, 0, 0, 0); tick();
      expect_next("runD_w1_intact", 32'd8, cw(1), 1, 0, 0, 0); tick();
      expect_next("runD_w2", 32'd12, cw(2), 1, 0, 0, 0); tick();

      // Fill the whole memory: load ends on MEM_DEPTH words without HALT
      i_rst = 1'b1;
      expect_next("rst_E", 0, 0, 0, 0, 0, 0); tick();
      i_rst = 1'b0;
      i_ld_start = 1'b1;
      expect_next("ldE_start", 0, 0, 0, 0, 0, 0); tick();
      i_ld_start = 1'b0;
      for (int i = 0; i < 256; i++) load_word(32'h0000_1000 + 32'(i), i, i == 255);
      expect_next("ldE_full_idle", 0, 0, 0, 0, 0, 256); tick();

      // Drain, bounded
      for (int k = 0; k < 5 && sb.size() > 0; k++) tick();
      if (sb.size() > 0) begin
         $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
         total += sb.size();
         bad   += sb.size();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
